// File: rtl/touch_region_colour_grid.sv
// Touch-editable colour grid: each screen rectangle holds a {green,blue,red} code,
// qualified touches edit the touched rectangle, and the LCD pixel request returns registered RGB.
module touch_region_colour_grid #(
   parameter int H_REGIONS      = 4,
   parameter int V_REGIONS      = 2,
   parameter int LEVEL_BITS     = 1,
   parameter int H_PIXELS       = 800,
   parameter int V_PIXELS       = 480,
   parameter int HOLDOFF_CYCLES = 5000000,
   localparam int HB   = $clog2(H_REGIONS),
   localparam int VB   = $clog2(V_REGIONS),
   localparam int NREG = H_REGIONS * V_REGIONS,
   localparam int RW   = (HB + VB) > 0 ? HB + VB : 1,
   localparam int CW   = 3 * LEVEL_BITS,
   localparam int REP  = (8 + LEVEL_BITS - 1) / LEVEL_BITS,
   localparam int HW   = HOLDOFF_CYCLES > 0 ? $clog2(HOLDOFF_CYCLES + 1) : 1
) (
   input  logic          Clock,
   input  logic          Resetn,
   input  logic [1:0]    Mode,
   input  logic          Touch_En,
   input  logic          Coord_En,
   input  logic [11:0]   X_Coord,
   input  logic [11:0]   Y_Coord,
   input  logic [9:0]    Pixel_X,
   input  logic [9:0]    Pixel_Y,
   output logic [7:0]    Red,
   output logic [7:0]    Green,
   output logic [7:0]    Blue,
   output logic          Event_Valid,
   output logic [RW-1:0] Last_Region,
   output logic [15:0]   Event_Count
);

   logic [CW-1:0] code [NREG];
   logic [CW-1:0] cur;
   logic [HW-1:0] hold;
   logic          coord_d;
   logic          accept;
   logic [RW-1:0] touch_idx;
   logic [RW-1:0] pix_idx;
   int            pcol, prow;

   // Top coordinate bits pick the region; a shift by 12 yields 0 for a single-region axis.
   assign touch_idx = RW'(int'(Y_Coord >> (12 - VB)) * H_REGIONS + int'(X_Coord >> (12 - HB)));
   assign accept    = Coord_En & ~coord_d & Touch_En & (hold == '0);

   // Column is the last boundary not beyond the pixel, so out-of-range pixels land in the last column.
   always_comb begin
      pcol = 0;
      prow = 0;
      for (int c = 1; c < H_REGIONS; c++)
         if (int'(Pixel_X) >= c * H_PIXELS / H_REGIONS) pcol = c;
      for (int r = 1; r < V_REGIONS; r++)
         if (int'(Pixel_Y) >= r * V_PIXELS / V_REGIONS) prow = r;
      pix_idx = RW'(prow * H_REGIONS + pcol);
   end

   assign cur = code[pix_idx];

   function automatic logic [7:0] expand(input logic [LEVEL_BITS-1:0] f);
      logic [REP*LEVEL_BITS-1:0] r;
      r = {REP{f}};
      return r[REP*LEVEL_BITS-1 -: 8];
   endfunction

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         coord_d     <= 1'b0;
         hold        <= '0;
         Event_Valid <= 1'b0;
         Last_Region <= '0;
         Event_Count <= '0;
         Red         <= '0;
         Green       <= '0;
         Blue        <= '0;
         for (int i = 0; i < NREG; i++) code[i] <= CW'(i);
      end else begin
         coord_d     <= Coord_En;
         Event_Valid <= accept;
         // Pixel reads the pre-update code when an edit lands on the same region.
         Red   <= expand(cur[LEVEL_BITS-1:0]);
         Blue  <= expand(cur[2*LEVEL_BITS-1:LEVEL_BITS]);
         Green <= expand(cur[3*LEVEL_BITS-1:2*LEVEL_BITS]);
         if (accept) begin
            hold        <= HW'(HOLDOFF_CYCLES);
            Last_Region <= touch_idx;
            if (Event_Count != 16'hFFFF) Event_Count <= Event_Count + 16'd1;
            case (Mode)
               2'b00: code[touch_idx] <= code[touch_idx] + 1'b1;
               2'b01: code[touch_idx] <= code[touch_idx] - 1'b1;
               2'b10: code[touch_idx] <= '0;
               default: for (int i = 0; i < NREG; i++) code[i] <= CW'(i);
            endcase
         end else if (hold != '0) begin
            hold <= hold - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_touch_region_colour_grid.sv
// Two grid configurations driven by shared random/directed stimulus and compared every cycle
// against an arithmetic reference model of the region codes, hold-off and event counter.
module tb_touch_region_colour_grid;

   logic        Clock = 1'b0;
   logic        Resetn = 1'b1;
   logic [1:0]  Mode = '0;
   logic        Touch_En = 1'b0, Coord_En = 1'b0;
   logic [11:0] X_Coord = '0, Y_Coord = '0;
   logic [9:0]  Pixel_X = '0, Pixel_Y = '0;

   logic [7:0]  a_red, a_green, a_blue, b_red, b_green, b_blue;
   logic        a_ev, b_ev;
   logic [2:0]  a_last;
   logic [4:0]  b_last;
   logic [15:0] a_cnt, b_cnt;

   int checks = 0, errors = 0;

   touch_region_colour_grid #(.HOLDOFF_CYCLES(16)) dut_a (
      .Clock(Clock), .Resetn(Resetn), .Mode(Mode), .Touch_En(Touch_En), .Coord_En(Coord_En),
      .X_Coord(X_Coord), .Y_Coord(Y_Coord), .Pixel_X(Pixel_X), .Pixel_Y(Pixel_Y),
      .Red(a_red), .Green(a_green), .Blue(a_blue),
      .Event_Valid(a_ev), .Last_Region(a_last), .Event_Count(a_cnt));

   touch_region_colour_grid #(.H_REGIONS(8), .V_REGIONS(4), .LEVEL_BITS(2), .HOLDOFF_CYCLES(0)) dut_b (
      .Clock(Clock), .Resetn(Resetn), .Mode(Mode), .Touch_En(Touch_En), .Coord_En(Coord_En),
      .X_Coord(X_Coord), .Y_Coord(Y_Coord), .Pixel_X(Pixel_X), .Pixel_Y(Pixel_Y),
      .Red(b_red), .Green(b_green), .Blue(b_blue),
      .Event_Valid(b_ev), .Last_Region(b_last), .Event_Count(b_cnt));

   always #10 Clock = ~Clock;

   // Reference model state, one slot per configuration
   int cfg_h [2] = '{4, 8};
   int cfg_v [2] = '{2, 4};
   int cfg_l [2] = '{1, 2};
   int cfg_n [2] = '{16, 0};
   int m_code [2][32];
   int m_since [2];
   int m_cnt [2];
   int m_last [2];
   bit exp_ev [2];
   bit m_prev;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 32; i++) m_code[d][i] = i % (1 << (3 * cfg_l[d]));
         m_since[d] = 1000000;
         m_cnt[d] = 0;
         m_last[d] = 0;
         exp_ev[d] = 0;
      end
      m_prev = 0;
   endtask

   function automatic logic [23:0] exp_rgb(input int d, input int px, input int py);
      int h, v, col, row, c, m, s;
      h = cfg_h[d];
      v = cfg_v[d];
      col = ((px + 1) * h + 800 - 1) / 800 - 1;
      row = ((py + 1) * v + 480 - 1) / 480 - 1;
      if (col > h - 1) col = h - 1;
      if (row > v - 1) row = v - 1;
      c = m_code[d][row * h + col];
      m = 1 << cfg_l[d];
      s = 255 / (m - 1);
      return {8'((c % m) * s), 8'((c / (m * m)) * s), 8'(((c / m) % m) * s)};
   endfunction

   task automatic model_edge(input int d);
      int h, m, r;
      h = cfg_h[d];
      m = 1 << (3 * cfg_l[d]);
      r = (int'(Y_Coord) * cfg_v[d] / 4096) * h + int'(X_Coord) * h / 4096;
      if (m_since[d] < 1000000) m_since[d]++;
      exp_ev[d] = Coord_En && !m_prev && Touch_En && (m_since[d] > cfg_n[d]);
      if (exp_ev[d]) begin
         m_since[d] = 0;
         m_last[d] = r;
         if (m_cnt[d] < 65535) m_cnt[d]++;
         case (Mode)
            2'd0: m_code[d][r] = (m_code[d][r] + 1) % m;
            2'd1: m_code[d][r] = (m_code[d][r] + m - 1) % m;
            2'd2: m_code[d][r] = 0;
            default: for (int i = 0; i < h * cfg_v[d]; i++) m_code[d][i] = i % m;
         endcase
      end
   endtask

   task automatic step();
      logic [23:0] er [2];
      @(posedge Clock);
      for (int d = 0; d < 2; d++) er[d] = exp_rgb(d, int'(Pixel_X), int'(Pixel_Y));
      for (int d = 0; d < 2; d++) model_edge(d);
      m_prev = Coord_En;
      #1;
      chk("a_rgb", {a_red, a_green, a_blue}, er[0]);
      chk("a_event_valid", a_ev, exp_ev[0]);
      chk("a_last_region", a_last, m_last[0]);
      chk("a_event_count", a_cnt, m_cnt[0]);
      chk("b_rgb", {b_red, b_green, b_blue}, er[1]);
      chk("b_event_valid", b_ev, exp_ev[1]);
      chk("b_last_region", b_last, m_last[1]);
      chk("b_event_count", b_cnt, m_cnt[1]);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         Coord_En = 1'b0;
         Pixel_X = 10'($urandom_range(0, 1023));
         Pixel_Y = 10'($urandom_range(0, 1023));
         step();
      end
   endtask

   task automatic touch_on(input logic [1:0] m, input logic [11:0] x, input logic [11:0] y);
      Mode = m;
      X_Coord = x;
      Y_Coord = y;
      Touch_En = 1'b1;
      Coord_En = 1'b1;
      step();
   endtask

   task automatic touch_off();
      Coord_En = 1'b0;
      step();
   endtask

   task automatic pixel(input int x, input int y);
      Pixel_X = 10'(x);
      Pixel_Y = 10'(y);
      step();
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_a_rgb"}, {a_red, a_green, a_blue}, 0);
      chk({tag, "_a_ev"}, a_ev, 0);
      chk({tag, "_a_last"}, a_last, 0);
      chk({tag, "_a_cnt"}, a_cnt, 0);
      chk({tag, "_b_rgb"}, {b_red, b_green, b_blue}, 0);
      chk({tag, "_b_ev"}, b_ev, 0);
      chk({tag, "_b_last"}, b_last, 0);
      chk({tag, "_b_cnt"}, b_cnt, 0);
   endtask

   int          sx [5] = '{0, 199, 200, 799, 900};
   logic [23:0] srgb [5] = '{24'h000000, 24'h000000, 24'hFF0000, 24'hFF00FF, 24'hFF00FF};
   int          c0;

   initial begin
      model_reset();
      #1 Resetn = 1'b0;
      #3 check_zero("reset");
      @(negedge Clock);
      Resetn = 1'b1;

      for (int i = 0; i < 5; i++) begin
         pixel(sx[i], 100);
         chk("sweep_rgb", {a_red, a_green, a_blue}, srgb[i]);
      end

      touch_on(2'd0, 12'hC00, 12'h800);
      chk("wrap_ev", a_ev, 1);
      chk("wrap_last", a_last, 7);
      chk("wrap_cnt", a_cnt, 1);
      touch_off();
      chk("wrap_ev_off", a_ev, 0);
      pixel(700, 300);
      chk("wrap_rgb", {a_red, a_green, a_blue}, 24'h000000);

      idle(20);
      c0 = int'(a_cnt);
      touch_on(2'd0, 12'hC00, 12'h800);
      touch_off();
      idle(8);
      touch_on(2'd0, 12'hC00, 12'h800);
      chk("holdoff_drop_cnt", a_cnt, c0 + 1);
      chk("holdoff_drop_ev", a_ev, 0);
      touch_off();
      idle(8);
      touch_on(2'd0, 12'hC00, 12'h800);
      chk("holdoff_accept_cnt", a_cnt, c0 + 2);

      touch_off();
      idle(20);
      touch_on(2'd1, 12'h000, 12'h000);
      touch_off();
      pixel(0, 0);
      chk("dec_rgb", {a_red, a_green, a_blue}, 24'hFFFFFF);
      idle(20);
      touch_on(2'd2, 12'h400, 12'h800);
      chk("clear_last", a_last, 5);
      touch_off();
      pixel(300, 300);
      chk("clear_rgb", {a_red, a_green, a_blue}, 24'h000000);
      idle(20);
      touch_on(2'd3, 12'h000, 12'h000);
      touch_off();
      pixel(300, 300);
      chk("restore_rgb", {a_red, a_green, a_blue}, 24'hFFFF00);

      idle(20);
      touch_on(2'd0, 12'h200, 12'h400);
      chk("gen_last", b_last, 9);
      touch_off();
      pixel(150, 150);
      chk("gen_rgb", {b_red, b_green, b_blue}, 24'hAA00AA);

      idle(20);
      c0 = int'(a_cnt);
      Mode = 2'd0;
      Touch_En = 1'b1;
      Coord_En = 1'b1;
      repeat (1000) begin
         Pixel_X = 10'($urandom_range(0, 1023));
         Pixel_Y = 10'($urandom_range(0, 1023));
         step();
      end
      chk("held_single_event", a_cnt, c0 + 1);
      touch_off();

      repeat (3000) begin
         Mode = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         Touch_En = ($urandom_range(0, 3) != 0);
         Coord_En = 1'($urandom_range(0, 1));
         X_Coord = 12'($urandom);
         Y_Coord = 12'($urandom);
         Pixel_X = 10'($urandom_range(0, 1023));
         Pixel_Y = 10'($urandom_range(0, 1023));
         step();
      end

      idle(20);
      touch_on(2'd0, 12'h400, 12'h000);
      chk("pre_reset_ev", a_ev, 1);
      Resetn = 1'b0;
      #1 check_zero("async_reset");
      model_reset();
      Coord_En = 1'b0;
      @(negedge Clock);
      Resetn = 1'b1;
      idle(5);
      pixel(799, 100);
      chk("post_reset_rgb", {a_red, a_green, a_blue}, 24'hFF00FF);
      idle(10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
